uart_rx_oversample: RTL

Oversampling UART receiver that sits directly upstream of the range-finder UART controller's byte consumer. It deframes 8-N-1 serial data from the device pin into whole bytes with a valid/ready handshake, so downstream logic sees bytes rather than raw bit timing. It synchronises the asynchronous RX pin, samples each bit 16 times, rejects start-bit glitches, and flags framing and overrun errors.

---
 rtl/uart_rx_oversample_pkg.sv | 29 ++
 rtl/uart_rx_oversample_if.sv | 11 +
 rtl/uart_rx_oversample_baud_tick.sv | 32 +++
 rtl/uart_rx_oversample.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_oversample_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// oversampling constants, the baud divider calculation and the
// three-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A   = 7;
  localparam int SAMPLE_B   = 8;
  localparam int SAMPLE_C   = 9;

  // Clock cycles per oversample tick, truncated; callers need a result >= 2.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Received-byte stream: DATA/VALID from the receiver, READY from the consumer.
// A byte transfers on any CLK edge where VALID && READY.
// The receiver never waits on READY; an unconsumed byte is overwritten.
interface uart_rx_oversample_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;

  modport master (output DATA, output VALID, input READY);
  modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/uart_rx_oversample_baud_tick.sv
// Free-running divider that emits a one-cycle TICK every DIV clocks.
// Latency: TICK asserts DIV cycles after CLR (counter value DIV-1).
// No backpressure; CLR restarts the period from zero.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign TICK = (cnt_q == CW'(DIV - 1));

  // Next count: wrap at the tick, restart on CLR.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (CLR || TICK) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver: 8-N-1 (8-E-1 when UART_RX_PARITY_EN is defined).
// Latency: byte VALID one cycle after the stop-bit vote (~9.6 bit times from start edge).
// No backpressure: a byte landing on an unconsumed VALID overwrites it and sets OVERRUN.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        RX,
  uart_rx_oversample_if.master        BYTE,
  output logic                        FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  output logic                        PARITY_ERR,
`endif
  output logic                        OVERRUN,
  output logic                        BUSY
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        tick, tick_clr;
  uart_state_e state_q, state_d;
  logic [3:0]  sample_q, sample_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        s7_q, s7_d, s8_q, s8_d;
  logic [7:0]  data_q;
  logic        valid_q, ferr_q, ovr_q;
  logic        vote, at_vote, at_wrap, commit, ferr;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d, perr, perr_q;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (tick_clr),
    .TICK  (tick)
  );

  assign vote    = majority3(s7_q, s8_q, rx_sync_q);
  assign at_vote = tick && (sample_q == 4'(SAMPLE_C));
  assign at_wrap = tick && (sample_q == 4'(OVERSAMPLE - 1));

  // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Frame FSM: sample capture, bit votes and stop-bit decision.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    tick_clr = 1'b0;
    commit   = 1'b0;
    ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr      = 1'b0;
`endif
    if (tick) begin
      sample_d = sample_q + 4'd1;
      if (sample_q == 4'(SAMPLE_A)) s7_d = rx_sync_q;
      if (sample_q == 4'(SAMPLE_B)) s8_d = rx_sync_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          tick_clr = 1'b1;
          sample_d = '0;
          state_d  = ST_START;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;            // start bit did not hold low: glitch
        end else if (at_wrap) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (at_vote) shift_d[idx_q] = vote;
        if (at_wrap) begin
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (at_vote) par_bad_d = ^{shift_q, vote};
        if (at_wrap) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (at_vote) begin
`ifdef UART_RX_PARITY_EN
          perr = par_bad_q;
`endif
          if (vote) begin
            // Leave mid stop bit so a back-to-back start edge is caught.
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            commit = !par_bad_q;
`else
            commit = 1'b1;
`endif
          end else begin
            ferr    = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_sync_q) state_d = ST_IDLE;  // a held-low break yields no bytes
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      s7_q     <= 1'b1;
      s8_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      s7_q     <= s7_d;
      s8_q     <= s8_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Output byte, handshake and error flags; a commit beats a same-cycle consume.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      ferr_q <= ferr;
`ifdef UART_RX_PARITY_EN
      perr_q <= perr;
`endif
      if (commit) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
        if (valid_q && !BYTE.READY) ovr_q <= 1'b1;
      end else if (valid_q && BYTE.READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign BYTE.DATA  = data_q;
  assign BYTE.VALID = valid_q;
  assign FRAME_ERR  = ferr_q;
  assign OVERRUN    = ovr_q;
  assign BUSY       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = perr_q;
`endif

endmodule
